// File: rtl/uart_frame_rx.sv
// Frame parser behind the UART receiver: SYNC, CMD, LEN, payload, CSUM.
// Streams payload bytes as they arrive and pulses frame_ok / frame_err at frame end.
module uart_frame_rx #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hAA,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 5_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        pay_valid,
  output logic [7:0]  pay_data,
  output logic [7:0]  pay_index,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [7:0]  frame_cmd,
  output logic [7:0]  frame_len,
  output logic [15:0] frame_cnt
);

  localparam int unsigned    TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [1:0]     E_LEN     = 2'd1;
  localparam logic [1:0]     E_CSUM    = 2'd2;
  localparam logic [1:0]     E_TMO     = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_LEN, S_PAYLOAD, S_CSUM} state_e;

  state_e         state_q, state_d;
  logic [7:0]     sum_q, sum_d;
  logic [7:0]     idx_q, idx_d;
  logic [7:0]     cmd_q, cmd_d;
  logic [7:0]     len_q, len_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           pay_valid_q, pay_valid_d;
  logic [7:0]     pay_data_q, pay_data_d;
  logic [7:0]     pay_index_q, pay_index_d;
  logic           frame_ok_q, frame_ok_d;
  logic           frame_err_q, frame_err_d;
  logic [1:0]     err_code_q, err_code_d;
  logic [7:0]     frame_cmd_q, frame_cmd_d;
  logic [7:0]     frame_len_q, frame_len_d;
  logic [15:0]    frame_cnt_q, frame_cnt_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d     = state_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    cmd_d       = cmd_q;
    len_d       = len_q;
    tmo_d       = tmo_q;
    pay_valid_d = 1'b0;
    pay_data_d  = pay_data_q;
    pay_index_d = pay_index_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    frame_cmd_d = frame_cmd_q;
    frame_len_d = frame_len_q;
    frame_cnt_d = frame_cnt_q;

    if (rx_valid) begin
      // A byte always beats a coincident timeout expiry.
      tmo_d = '0;
      case (state_q)
        S_IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = S_CMD;
            sum_d   = 8'd0;
          end
        end
        S_CMD: begin
          cmd_d   = rx_data;
          sum_d   = sum_q + rx_data;
          state_d = S_LEN;
        end
        S_LEN: begin
          if (rx_data > MAX_LEN_B) begin
            frame_err_d = 1'b1;
            err_code_d  = E_LEN;
            state_d     = S_IDLE;
          end else begin
            len_d   = rx_data;
            sum_d   = sum_q + rx_data;
            idx_d   = 8'd0;
            state_d = (rx_data == 8'd0) ? S_CSUM : S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          pay_valid_d = 1'b1;
          pay_data_d  = rx_data;
          pay_index_d = idx_q;
          sum_d       = sum_q + rx_data;
          idx_d       = idx_q + 8'd1;
          if (idx_q == len_q - 8'd1) state_d = S_CSUM;
        end
        S_CSUM: begin
          if (rx_data == sum_q) begin
            frame_ok_d  = 1'b1;
            frame_cmd_d = cmd_q;
            frame_len_d = len_q;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = E_CSUM;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      if (tmo_q == TMO_LAST) begin
        frame_err_d = 1'b1;
        err_code_d  = E_TMO;
        state_d     = S_IDLE;
        tmo_d       = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge sys_clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
    if (sys_rst) begin
      state_q     <= S_IDLE;
      sum_q       <= '0;
      idx_q       <= '0;
      cmd_q       <= '0;
      len_q       <= '0;
      tmo_q       <= '0;
      pay_valid_q <= 1'b0;
      pay_data_q  <= '0;
      pay_index_q <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
      frame_cmd_q <= '0;
      frame_len_q <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      cmd_q       <= cmd_d;
      len_q       <= len_d;
      tmo_q       <= tmo_d;
      pay_valid_q <= pay_valid_d;
      pay_data_q  <= pay_data_d;
      pay_index_q <= pay_index_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      frame_cmd_q <= frame_cmd_d;
      frame_len_q <= frame_len_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign pay_valid = pay_valid_q;
  assign pay_data  = pay_data_q;
  assign pay_index = pay_index_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign frame_cmd = frame_cmd_q;
  assign frame_len = frame_len_q;
  assign frame_cnt = frame_cnt_q;

endmodule
